mem_port_arbiter: RTL

//  Shares one scratchpad data port between NR requesters (core imem, core dmem, HTIF).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port constants: memory function codes and access-size codes
// used by the core/HTIF request ports and the scratchpad.
package mem_port_arbiter_pkg;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } mem_fcn_t;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } mem_typ_t;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter: round-robin pick among N requesters.
//  clk, rst : clock, async active-high reset (clears the pointer)
//  req      : request vector
//  grant    : one-hot winner, zero if no request
//  idx      : encoded winner index (0 when no request)
//  any      : at least one request (a transfer happens this cycle)
// The winner is the first requesting index at or after ptr, wrapping; ptr
// advances to winner+1 on every transfer and holds when idle.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  logic [$clog2(N)-1:0] ptr;
  int unsigned          cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = ($clog2(N))'(cand);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (32'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one scratchpad port among NR requesters
// (0=imem, 1=dmem, 2=HTIF) with round-robin grant, one transfer per cycle.
// Read responses are steered back to the issuer through a LAT-deep grant-ID
// pipeline.
//  clk, rst       : clock, async active-high reset
//  rq_valid/ready : per-requester handshake (ready is one-hot winner)
//  rq_addr/fcn/typ/data : packed per-requester request fields
//  rs_valid       : one-hot read response valid; rs_data shared
//  mem_req_*      : muxed request to memory; mem_resp_data read data
//  busy           : any read in flight
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NR  = 3,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    rq_valid,
  output logic [NR-1:0]    rq_ready,
  input  logic [NR*AW-1:0] rq_addr,
  input  logic [NR-1:0]    rq_fcn,
  input  logic [NR*3-1:0]  rq_typ,
  input  logic [NR*DW-1:0] rq_data,
  output logic [NR-1:0]    rs_valid,
  output logic [DW-1:0]    rs_data,
  output logic             mem_req_valid,
  output logic [AW-1:0]    mem_req_addr,
  output logic             mem_req_fcn,
  output logic [2:0]       mem_req_typ,
  output logic [DW-1:0]    mem_req_data,
  input  logic [DW-1:0]    mem_resp_data,
  output logic             busy
);

  localparam int unsigned IW = $clog2(NR);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } inflight_t;

  logic [NR-1:0] grant;
  logic [IW-1:0] win;
  logic          any;
  logic          is_read;
  inflight_t     pipe [LAT];

  rr_arbiter #(.N(NR)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (rq_valid),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  // Handshake is masked while reset is held so nothing is accepted then.
  assign rq_ready      = rst ? '0 : grant;
  assign mem_req_valid = any & ~rst;

  always_comb begin
    mem_req_addr = rq_addr[win*AW +: AW];
    mem_req_fcn  = rq_fcn[win];
    mem_req_typ  = rq_typ[win*3 +: 3];
    mem_req_data = rq_data[win*DW +: DW];
  end

  assign is_read = mem_req_valid && (mem_req_fcn == M_XRD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: is_read, id: win};
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    rs_valid = '0;
    if (pipe[LAT-1].v) rs_valid[pipe[LAT-1].id] = 1'b1;
    rs_data = mem_resp_data;
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) busy = busy | pipe[i].v;
  end

endmodule
